// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I data-memory controller with byte-lane stores, stalled loads and a memory-mapped LED register
// Ports: clk, rst_n (async active-low); addr/write_data/memwrite/memread/sign_mask from the core;
// read_data and clk_stall back to the core; led register output; err_misaligned pulse.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of aligning them).
module data_mem_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] DATA_BASE   = 32'h0000_4000,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
    parameter int          LED_WIDTH   = 8,
    parameter              DATA_INIT   = "verilog/data.hex"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic                 clk_stall,
    output logic [LED_WIDTH-1:0] led,
    output logic                 err_misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;
    // The preload image named by DATA_INIT is applied by the memory-init flow of the target, not by this RTL.
    if ($bits(DATA_INIT) == 0) begin : g_no_image
    end
    logic [31:0] mem [DEPTH_WORDS];
    state_t state_q, state_d;
    logic [1:0] off_q, off_d;
    logic is_word_q, is_word_d, is_half_q, is_half_d, sign_q, sign_d;
    logic src_data_q, src_data_d, src_led_q, src_led_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0] word_buf_q, word_buf_d, read_data_q, read_data_d;
    logic stall_q, stall_d, err_q, err_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic is_word, is_half, mis, in_data, in_led, idle, ld_start, do_st;
    logic [31:0] eff_addr, rel, wdata, sh, ext;
    logic [3:0] lane_en;
    assign is_word = sign_mask[2:0] == 3'b111;
    assign is_half = sign_mask[2:0] == 3'b011;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis      = (is_half & addr[0]) | (is_word & |addr[1:0]);
    assign eff_addr = addr;
`else
    // Half and word accesses silently drop the low address bits.
    assign mis      = 1'b0;
    assign eff_addr = {addr[31:2], addr[1] & ~is_word, addr[0] & ~is_word & ~is_half};
`endif
    always_comb begin
        rel      = eff_addr - DATA_BASE;
        in_data  = (eff_addr >= DATA_BASE) && (rel < 32'(4 * DEPTH_WORDS));
        in_led   = (eff_addr == LED_ADDR) && is_word;
        idle     = state_q == IDLE;
        // A store wins over a simultaneous load.
        ld_start = idle & memread & ~memwrite;
        do_st    = idle & memwrite & in_data & ~mis;
        lane_en  = is_word ? 4'hf : is_half ? (eff_addr[1] ? 4'hc : 4'h3) : 4'b0001 << eff_addr[1:0];
        wdata    = is_word ? write_data : is_half ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
        state_d  = ld_start ? LOAD : state_q == LOAD ? RESP : IDLE;
        stall_d  = state_d != IDLE;
        off_d      = ld_start ? eff_addr[1:0] : off_q;
        is_word_d  = ld_start ? is_word : is_word_q;
        is_half_d  = ld_start ? is_half : is_half_q;
        sign_d     = ld_start ? sign_mask[3] : sign_q;
        // Misaligned or unmapped loads read from no source and so return 0.
        src_data_d = ld_start ? in_data & ~mis : src_data_q;
        src_led_d  = ld_start ? in_led & ~mis : src_led_q;
        idx_d      = ld_start ? rel[AW+1:2] : idx_q;
        word_buf_d = state_q != LOAD ? word_buf_q : src_data_q ? mem[idx_q] : src_led_q ? 32'(led_q) : 32'h0;
        sh  = word_buf_q >> {off_q, 3'b000};
        ext = is_word_q ? sh : is_half_q ? {{16{sign_q & sh[15]}}, sh[15:0]} : {{24{sign_q & sh[7]}}, sh[7:0]};
        read_data_d = state_q == RESP ? ext : read_data_q;
        led_d = (idle & memwrite & in_led & ~mis) ? write_data[LED_WIDTH-1:0] : led_q;
        err_d = idle & (memwrite | memread) & (in_data | in_led) & mis;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            read_data_q <= '0;
            led_q       <= '0;
            err_q       <= 1'b0;
            off_q       <= '0;
            is_word_q   <= 1'b0;
            is_half_q   <= 1'b0;
            sign_q      <= 1'b0;
            src_data_q  <= 1'b0;
            src_led_q   <= 1'b0;
            idx_q       <= '0;
            word_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
            err_q       <= err_d;
            off_q       <= off_d;
            is_word_q   <= is_word_d;
            is_half_q   <= is_half_d;
            sign_q      <= sign_d;
            src_data_q  <= src_data_d;
            src_led_q   <= src_led_d;
            idx_q       <= idx_d;
            word_buf_q  <= word_buf_d;
        end
    end
    // Array has no reset so a reset during a load leaves contents intact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (do_st && lane_en[i]) mem[rel[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
    assign read_data      = read_data_q;
    assign clk_stall      = stall_q;
    assign led            = led_q;
    assign err_misaligned = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table-driven, hand-sequenced and randomized checks of data_mem_ctrl against a byte-array model
module tb_data_mem_ctrl;
    localparam logic [31:0] DB  = 32'h0000_4000;
    localparam logic [31:0] LED = 32'h0000_2000;
    localparam int DEPTH = 1024;
    logic clk = 0, rst_n = 0, memwrite = 0, memread = 0, clk_stall, err_misaligned;
    logic [31:0] addr = 0, write_data = 0, read_data;
    logic [3:0] sign_mask = 0;
    logic [7:0] led;
    int errs = 0, checks = 0;
    logic [7:0] bm [4*DEPTH];
    logic [7:0] lm = 0;
    data_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data), .memwrite(memwrite),
        .memread(memread), .sign_mask(sign_mask), .read_data(read_data), .clk_stall(clk_stall),
        .led(led), .err_misaligned(err_misaligned)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic int nb(input logic [3:0] m);
        return m[2] ? 4 : m[1] ? 2 : 1;
    endfunction
    function automatic bit m_mis(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (a % nb(m)) != 0;
`else
        return 0;
`endif
    endfunction
    function automatic logic [31:0] m_ea(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_MISALIGN_TRAP_EN
        return a;
`else
        return a & ~(32'(nb(m)) - 1);
`endif
    endfunction
    function automatic bit m_data(input logic [31:0] ea);
        return ea >= DB && ea < DB + 4 * DEPTH;
    endfunction
    function automatic bit m_err(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] ea = m_ea(a, m);
        return m_mis(a, m) && (m_data(ea) || (ea == LED && nb(m) == 4));
    endfunction
    task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] ea = m_ea(a, m);
        if (m_mis(a, m)) return;
        if (m_data(ea)) for (int i = 0; i < nb(m); i++) bm[int'(ea - DB) + i] = d[8*i +: 8];
        if (ea == LED && nb(m) == 4) lm = d[7:0];
    endtask
    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] ea = m_ea(a, m);
        logic [31:0] v = 0;
        int n = nb(m);
        if (m_mis(a, m)) return 0;
        if (ea == LED && n == 4) return {24'h0, lm};
        if (!m_data(ea)) return 0;
        for (int i = 0; i < n; i++) v |= 32'(bm[int'(ea - DB) + i]) << (8 * i);
        if (m[3] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit rd);
        bit e = m_err(a, m);
        @(negedge clk);
        addr = a; write_data = d; sign_mask = m; memwrite = 1; memread = rd;
        @(posedge clk);
        #1;
        memwrite = 0; memread = 0;
        m_store(a, d, m);
        chk("st_err", 32'(err_misaligned), 32'(e));
        chk("st_stall", 32'(clk_stall), 0);
        chk("st_led", 32'(led), 32'(lm));
    endtask
    task automatic do_load(input logic [31:0] a, input logic [3:0] m, output logic [31:0] v);
        bit e = m_err(a, m);
        @(negedge clk);
        addr = a; sign_mask = m; memread = 1;
        @(posedge clk);
        #1;
        memread = 0;
        addr = $urandom; sign_mask = 4'($urandom);
        chk("ld_stall1", 32'(clk_stall), 1);
        chk("ld_err", 32'(err_misaligned), 32'(e));
        @(posedge clk);
        #1;
        chk("ld_stall2", 32'(clk_stall), 1);
        chk("ld_err_end", 32'(err_misaligned), 0);
        @(posedge clk);
        #1;
        chk("ld_stall_end", 32'(clk_stall), 0);
        v = read_data;
    endtask
    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[14];
    logic [3:0] masks[6] = '{4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0111, 4'b1111};
    initial begin
        logic [31:0] v, a;
        logic [3:0] m;
        tv[0]  = '{1, DB + 8,  32'hDEADBEEF, 4'b1111, 32'h0};
        tv[1]  = '{0, DB + 8,  32'h0,        4'b1111, 32'hDEADBEEF};
        tv[2]  = '{1, DB + 9,  32'h80,       4'b0001, 32'h0};
        tv[3]  = '{0, DB + 9,  32'h0,        4'b1001, 32'hFFFFFF80};
        tv[4]  = '{0, DB + 9,  32'h0,        4'b0001, 32'h00000080};
        tv[5]  = '{0, DB + 8,  32'h0,        4'b0111, 32'hDEAD80EF};
        tv[6]  = '{1, DB + 10, 32'h1234,     4'b0011, 32'h0};
        tv[7]  = '{0, DB + 10, 32'h0,        4'b1011, 32'h00001234};
        tv[8]  = '{0, DB + 8,  32'h0,        4'b0111, 32'h123480EF};
        tv[9]  = '{1, LED,     32'h5A,       4'b0111, 32'h5A};
        tv[10] = '{0, LED,     32'h0,        4'b0111, 32'h5A};
        tv[11] = '{0, 32'h0,   32'h0,        4'b0111, 32'h0};
        tv[12] = '{1, 32'h0,   32'hFF,       4'b0111, 32'h5A};
        tv[13] = '{1, LED,     32'h33,       4'b0011, 32'h5A};
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(clk_stall), 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_err", 32'(err_misaligned), 0);
        rst_n = 1;
        for (int w = 0; w < 16; w++) do_store(DB + 32'(4 * w), $urandom, 4'b0111, 0);
        for (int i = 0; i < 14; i++) begin
            if (tv[i].wr) begin
                do_store(tv[i].a, tv[i].d, tv[i].m, 0);
                chk($sformatf("tbl%0d_led", i), 32'(led), tv[i].exp);
            end else begin
                do_load(tv[i].a, tv[i].m, v);
                chk($sformatf("tbl%0d_load", i), v, tv[i].exp);
            end
        end
        do_store(DB, 32'hA5A5A5A5, 4'b0111, 0);
        do_store(DB + 2, 32'h11111111, 4'b0111, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_err_pulse", 32'(err_misaligned), 1);
`else
        chk("mis_err_pulse", 32'(err_misaligned), 0);
`endif
        @(posedge clk);
        #1;
        chk("mis_err_gone", 32'(err_misaligned), 0);
        do_load(DB, 4'b0111, v);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_word_kept", v, 32'hA5A5A5A5);
`else
        chk("mis_word_kept", v, 32'h11111111);
`endif
        do_load(DB + 1, 4'b1011, v);
        chk("mis_half_load", v, m_load(DB + 1, 4'b1011));
        do_store(DB + 4, 32'hCAFE0001, 4'b0111, 1);
        do_load(DB + 4, 4'b0111, v);
        chk("rw_both", v, 32'hCAFE0001);
        @(negedge clk);
        addr = DB + 4; sign_mask = 4'b0111; memread = 1;
        @(posedge clk);
        #1;
        memread = 0;
        chk("abort_stall_hi", 32'(clk_stall), 1);
        #2 rst_n = 0;
        #1;
        lm = 0;
        chk("abort_stall", 32'(clk_stall), 0);
        chk("abort_rdata", read_data, 0);
        chk("abort_led", 32'(led), 0);
        @(negedge clk);
        rst_n = 1;
        do_load(DB + 4, 4'b0111, v);
        chk("after_abort", v, 32'hCAFE0001);
        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 9);
            int s = $urandom_range(0, 9);
            m = masks[$urandom_range(0, 5)];
            a = s < 8 ? DB + 32'($urandom_range(0, 63)) : s == 8 ? LED + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 255));
            if (r < 4 || r == 9) do_store(a, $urandom, m, r == 9);
            else begin
                do_load(a, m, v);
                chk("rnd_load", v, m_load(a, m));
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
